// File: rtl/irr_priority_resolver_if.sv
// Bus between the 8259 interrupt front end (irr_priority_resolver) and
// Control_logic. The resolver takes the slave modport; whoever drives the
// request lines and control words takes the master modport.
// The optional special_mask_mode signal exists only when SPECIAL_MASK_EN
// is defined.
interface irr_priority_resolver_if;
    logic [7:0] IR;
    logic       ICW1_LTIM;
    logic [7:0] OCW1;
    logic [7:0] ISR;
    logic       begin_to_set_ISR;
    logic       eoi_pulse;
    logic [2:0] reset_by_EOI;
    logic       auto_rotate_status;
`ifdef SPECIAL_MASK_EN
    logic       special_mask_mode;
`endif
    logic [7:0] IRR;
    logic [2:0] highest_priority_IRR;
    logic [2:0] ack_id;
    logic       INT_request;

    modport master (
`ifdef SPECIAL_MASK_EN
        output special_mask_mode,
`endif
        output IR, ICW1_LTIM, OCW1, ISR, begin_to_set_ISR, eoi_pulse,
        output reset_by_EOI, auto_rotate_status,
        input  IRR, highest_priority_IRR, ack_id, INT_request
    );

    modport slave (
`ifdef SPECIAL_MASK_EN
        input  special_mask_mode,
`endif
        input  IR, ICW1_LTIM, OCW1, ISR, begin_to_set_ISR, eoi_pulse,
        input  reset_by_EOI, auto_rotate_status,
        output IRR, highest_priority_IRR, ack_id, INT_request
    );
endinterface

// File: rtl/irr_priority_resolver.sv
// irr_priority_resolver: 8259 front end. Synchronises IR0..IR7, latches
// them into the IRR (edge or level mode), applies the OCW1 mask, picks the
// highest-priority pending request under a rotating priority pointer and
// raises INT_request when that request outranks everything in service.
// Optional feature macro: SPECIAL_MASK_EN (adds special_mask_mode, which
// lets ISR bits that are masked in OCW1 stop blocking lower levels).
module irr_priority_resolver #(
    parameter int         NUM_IR       = 8,
    parameter logic [2:0] RESET_LOWEST = 3'b111
) (
    input logic                    clk,
    input logic                    reset,
    irr_priority_resolver_if.slave bus
);

    logic [NUM_IR-1:0] irSync1_q;
    logic [NUM_IR-1:0] irSync2_q;
    logic [NUM_IR-1:0] ir_q;
    logic [NUM_IR-1:0] irr_q, irr_d;
    logic [2:0]        pointer_q, pointer_d;
    logic [2:0]        highestPriority_q, highestPriority_d;
    logic [2:0]        ackId_q, ackId_d;
    logic              intRequest_q, intRequest_d;

    logic [NUM_IR-1:0] candidates;
    logic [NUM_IR-1:0] isrBlocking;
    logic [NUM_IR-1:0] risingEdge;
    logic [3:0]        winnerRank;
    logic [3:0]        minIsrRank;
    logic [3:0]        rank;

    // Two-flop synchroniser per line, then one more stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            irSync1_q <= '0;
            irSync2_q <= '0;
            ir_q      <= '0;
        end else begin
            irSync1_q <= bus.IR;
            irSync2_q <= irSync1_q;
            ir_q      <= irSync2_q;
        end
    end

    assign risingEdge = irSync2_q & ~ir_q;
    assign candidates = irr_q & ~bus.OCW1;

`ifdef SPECIAL_MASK_EN
    assign isrBlocking = bus.special_mask_mode ? (bus.ISR & ~bus.OCW1) : bus.ISR;
`else
    assign isrBlocking = bus.ISR;
`endif

    // Rotated-priority search: rank 0 is the level just above the pointer
    always_comb begin
        winnerRank        = 4'd8;
        minIsrRank        = 4'd8;
        rank              = 4'd0;
        highestPriority_d = highestPriority_q;
        for (int i = 0; i < NUM_IR; i++) begin
            rank = {1'b0, 3'(i) - pointer_q - 3'd1};
            if (isrBlocking[i] && (rank < minIsrRank)) begin
                minIsrRank = rank;
            end
            if (candidates[i] && (rank < winnerRank)) begin
                winnerRank        = rank;
                highestPriority_d = 3'(i);
            end
        end
        intRequest_d = (winnerRank < minIsrRank);
    end

    // IRR update: level mode mirrors the synchronised lines, edge mode
    // latches rising edges and clears the acknowledged bit (a new edge wins)
    always_comb begin
        irr_d = irr_q;
        if (bus.ICW1_LTIM) begin
            irr_d = irSync2_q;
        end else begin
            if (bus.begin_to_set_ISR && intRequest_q) begin
                irr_d[highestPriority_q] = 1'b0;
            end
            irr_d = irr_d | risingEdge;
        end
    end

    // Acknowledge capture and priority rotation on automatic EOI
    always_comb begin
        ackId_d   = ackId_q;
        pointer_d = pointer_q;
        if (bus.begin_to_set_ISR) begin
            ackId_d = intRequest_q ? highestPriority_q : 3'b111;
        end
        if (bus.eoi_pulse && bus.auto_rotate_status) begin
            pointer_d = bus.reset_by_EOI;
        end
    end

    // State registers for IRR, pointer and the registered resolver outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            irr_q             <= '0;
            pointer_q         <= RESET_LOWEST;
            highestPriority_q <= 3'd0;
            ackId_q           <= 3'd0;
            intRequest_q      <= 1'b0;
        end else begin
            irr_q             <= irr_d;
            pointer_q         <= pointer_d;
            highestPriority_q <= highestPriority_d;
            ackId_q           <= ackId_d;
            intRequest_q      <= intRequest_d;
        end
    end

    assign bus.IRR                  = irr_q;
    assign bus.highest_priority_IRR = highestPriority_q;
    assign bus.ack_id               = ackId_q;
    assign bus.INT_request          = intRequest_q;

endmodule

// File: tb/tb_irr_priority_resolver.sv
// Testbench for irr_priority_resolver. Stimulus queues expected values with
// the cycle at which they are due; a monitor on the falling edge pops and
// compares them against the DUT outputs.
module tb_irr_priority_resolver;

    localparam int F_IRR = 0;
    localparam int F_HP  = 1;
    localparam int F_ACK = 2;
    localparam int F_INT = 3;

    typedef struct {
        int         due;
        string      name;
        int         field;
        logic [7:0] value;
    } expect_t;

    logic    clk = 1'b0;
    logic    reset;
    int      cycle = 0;
    int      checks = 0;
    int      passes = 0;
    expect_t sbQ[$];

    irr_priority_resolver_if bus();

    irr_priority_resolver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expectations
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: compare every expectation whose cycle has come
    always @(negedge clk) begin
        logic [7:0] actual;
        expect_t    e;
        for (int k = sbQ.size() - 1; k >= 0; k--) begin
            if (sbQ[k].due <= cycle) begin
                e = sbQ[k];
                sbQ.delete(k);
                case (e.field)
                    F_IRR:   actual = bus.IRR;
                    F_HP:    actual = {5'd0, bus.highest_priority_IRR};
                    F_ACK:   actual = {5'd0, bus.ack_id};
                    default: actual = {7'd0, bus.INT_request};
                endcase
                checks++;
                if (actual === e.value) begin
                    passes++;
                end else begin
                    $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                             e.name, actual, e.value, cycle);
                end
            end
        end
    end

    // Advance a number of clocks and land just after the rising edge
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Queue an expected value due after the given number of rising edges
    task automatic checkOutput(input string name, input int field,
                               input logic [7:0] value, input int delay);
        expect_t e;
        e.due   = cycle + delay;
        e.name  = name;
        e.field = field;
        e.value = value;
        sbQ.push_back(e);
    endtask

    task automatic doReset();
        reset                   = 1'b1;
        bus.IR                  = 8'h00;
        bus.ICW1_LTIM           = 1'b0;
        bus.OCW1                = 8'h00;
        bus.ISR                 = 8'h00;
        bus.begin_to_set_ISR    = 1'b0;
        bus.eoi_pulse           = 1'b0;
        bus.reset_by_EOI        = 3'd0;
        bus.auto_rotate_status  = 1'b0;
`ifdef SPECIAL_MASK_EN
        bus.special_mask_mode   = 1'b0;
`endif
        applyStimulus(2);
        reset = 1'b0;
    endtask

    initial begin
        doReset();
        checkOutput("reset_irr", F_IRR, 8'h00, 0);
        checkOutput("reset_hp",  F_HP,  8'd0,  0);
        checkOutput("reset_ack", F_ACK, 8'd0,  0);
        checkOutput("reset_int", F_INT, 8'd0,  0);
        applyStimulus(1);

        // Edge latch of IR5 with three-clock latency, held after IR drops
        bus.IR = 8'h20;
        checkOutput("edge_irr_early", F_IRR, 8'h00, 2);
        checkOutput("edge_irr",       F_IRR, 8'h20, 3);
        checkOutput("edge_int_early", F_INT, 8'd0,  3);
        checkOutput("edge_hp",        F_HP,  8'd5,  4);
        checkOutput("edge_int",       F_INT, 8'd1,  4);
        applyStimulus(5);
        bus.IR = 8'h00;
        applyStimulus(5);
        checkOutput("edge_irr_held", F_IRR, 8'h20, 0);
        applyStimulus(1);

        // Acknowledge clears the winner; in-service 5 blocks 6 and 7
        doReset();
        bus.IR = 8'hE0;
        applyStimulus(4);
        checkOutput("ack_pre_hp", F_HP, 8'd5, 0);
        bus.begin_to_set_ISR = 1'b1;
        checkOutput("ack_id5",   F_ACK, 8'd5,  1);
        checkOutput("ack_irr",   F_IRR, 8'hC0, 1);
        checkOutput("ack_hp6",   F_HP,  8'd6,  2);
        applyStimulus(1);
        bus.begin_to_set_ISR = 1'b0;
        checkOutput("ack_int_still", F_INT, 8'd1, 1);
        applyStimulus(1);
        bus.ISR = 8'h20;
        checkOutput("isr_blocks", F_INT, 8'd0, 1);
        applyStimulus(2);

        // New rising edge in the acknowledge cycle keeps the bit set
        doReset();
        bus.IR = 8'h08;
        applyStimulus(4);
        bus.IR = 8'h00;
        applyStimulus(3);
        bus.IR = 8'h08;
        applyStimulus(2);
        bus.begin_to_set_ISR = 1'b1;
        checkOutput("setwin_irr", F_IRR, 8'h08, 1);
        checkOutput("setwin_ack", F_ACK, 8'd3,  1);
        applyStimulus(1);
        checkOutput("setwin_clear", F_IRR, 8'h00, 1);
        applyStimulus(1);
        bus.begin_to_set_ISR = 1'b0;
        applyStimulus(1);

        // Masking
        doReset();
        bus.OCW1 = 8'h01;
        bus.IR   = 8'h09;
        checkOutput("mask_hp3", F_HP,  8'd3, 4);
        checkOutput("mask_int", F_INT, 8'd1, 4);
        applyStimulus(4);
        bus.OCW1 = 8'h09;
        checkOutput("mask_all_int", F_INT, 8'd0,  1);
        checkOutput("mask_all_irr", F_IRR, 8'h09, 1);
        checkOutput("mask_all_hp",  F_HP,  8'd3,  1);
        applyStimulus(2);

        // Rotation on automatic EOI; plain EOI leaves the pointer alone
        doReset();
        bus.eoi_pulse          = 1'b1;
        bus.auto_rotate_status = 1'b1;
        bus.reset_by_EOI       = 3'd2;
        applyStimulus(1);
        bus.eoi_pulse          = 1'b0;
        bus.auto_rotate_status = 1'b0;
        bus.IR                 = 8'h12;
        checkOutput("rot_hp4",  F_HP,  8'd4, 4);
        checkOutput("rot_int",  F_INT, 8'd1, 4);
        applyStimulus(4);
        bus.eoi_pulse    = 1'b1;
        bus.reset_by_EOI = 3'd4;
        checkOutput("eoi_norot_hp", F_HP, 8'd4, 2);
        applyStimulus(1);
        bus.eoi_pulse = 1'b0;
        applyStimulus(1);

        // Reset during acknowledge restores everything, pointer included
        bus.IR = 8'hFF;
        checkOutput("full_irr", F_IRR, 8'hFF, 3);
        checkOutput("full_hp3", F_HP,  8'd3,  4);
        applyStimulus(4);
        bus.begin_to_set_ISR = 1'b1;
        checkOutput("full_ack3",  F_ACK, 8'd3,  1);
        checkOutput("full_irrF7", F_IRR, 8'hF7, 1);
        applyStimulus(1);
        reset = 1'b1;
        checkOutput("rstack_irr", F_IRR, 8'h00, 1);
        checkOutput("rstack_ack", F_ACK, 8'd0,  1);
        checkOutput("rstack_int", F_INT, 8'd0,  1);
        checkOutput("rstack_hp",  F_HP,  8'd0,  1);
        applyStimulus(1);
        reset                = 1'b0;
        bus.begin_to_set_ISR = 1'b0;
        bus.OCW1             = 8'hED;
        checkOutput("rstack_ptr_hp", F_HP,  8'd1, 4);
        checkOutput("rstack_ptr_int", F_INT, 8'd1, 4);
        applyStimulus(5);

        // Level mode tracking, acknowledge without lasting effect
        doReset();
        bus.ICW1_LTIM = 1'b1;
        bus.IR = 8'h40;
        checkOutput("lvl_irr_early", F_IRR, 8'h00, 2);
        checkOutput("lvl_irr_set",   F_IRR, 8'h40, 3);
        checkOutput("lvl_irr_hold",  F_IRR, 8'h40, 7);
        checkOutput("lvl_irr_clr",   F_IRR, 8'h00, 8);
        applyStimulus(5);
        bus.IR = 8'h00;
        applyStimulus(4);
        bus.IR = 8'h40;
        checkOutput("lvl_int", F_INT, 8'd1, 4);
        applyStimulus(4);
        bus.begin_to_set_ISR = 1'b1;
        checkOutput("lvl_ack6",      F_ACK, 8'd6,  1);
        checkOutput("lvl_ack_irr",   F_IRR, 8'h40, 1);
        checkOutput("lvl_ack_irr2",  F_IRR, 8'h40, 2);
        applyStimulus(1);
        bus.begin_to_set_ISR = 1'b0;
        bus.IR = 8'h00;
        checkOutput("lvl_int_off", F_INT, 8'd0, 5);
        applyStimulus(5);
        bus.begin_to_set_ISR = 1'b1;
        checkOutput("spurious_ack7", F_ACK, 8'd7, 1);
        applyStimulus(1);
        bus.begin_to_set_ISR = 1'b0;

        // Drain outstanding expectations within a bounded number of cycles
        for (int k = 0; k < 20 && sbQ.size() > 0; k++) applyStimulus(1);
        if (sbQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/irr_priority_resolver.md
Name: irr_priority_resolver

Overview:
- Front-end stage of the 8259 PIC, directly upstream of Control_logic.
- Latches raw IR0..IR7 requests into the IRR, in edge or level mode per ICW1_LTIM.
- Applies the OCW1 mask, resolves the highest-priority pending request against the current ISR, and raises the INT request.
- Handles clearing on acknowledge and priority rotation.

Parameters:
- NUM_IR, 8, number of request lines; fixed at 8 for 8259 compatibility, the 3-bit IDs depend on it.
- RESET_LOWEST, 3'b111, priority pointer value after reset; IR0 is highest priority.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- IR  input  8  raw interrupt request lines, asynchronous to clk.
- ICW1_LTIM  input  1  1 = level-triggered, 0 = edge-triggered.
- OCW1  input  8  interrupt mask; 1 = masked.
- ISR  input  8  in-service register from Control_logic.
- begin_to_set_ISR  input  1  one-cycle pulse on first INTA; acknowledges the current winner.
- eoi_pulse  input  1  one-cycle pulse when an EOI is executed.
- reset_by_EOI  input  3  ID of the level released by the EOI.
- auto_rotate_status  input  1  rotate priority on EOI when 1.
- IRR  output  8  interrupt request register.
- highest_priority_IRR  output  3  ID of the current unmasked winner.
- ack_id  output  3  ID captured at acknowledge; Control_logic uses it for vector and ISR set.
- INT_request  output  1  request to Control_logic to drive INT.

Behaviour:
- Reset values, held while reset is high: IRR=0, ir_q=0, pointer=RESET_LOWEST, highest_priority_IRR=0, ack_id=0, INT_request=0.
- IR synchronisation: 2-flop synchroniser per line, then ir_q holds the previous synchronised sample.
- Edge mode (LTIM=0):
  - IRR[i] sets on a synchronised rising edge (sync & ~ir_q).
  - It stays set until acknowledged.
  - IR falling before acknowledge does not clear it.
- Level mode (LTIM=1): IRR[i] follows the synchronised IR each cycle. Acknowledge has no lasting effect.
- Latency: IR edge to IRR bit = 3 clk; IRR to INT_request / highest_priority_IRR = 1 clk (both registered).
- Candidate set: IRR & ~OCW1.
- Priority order: pointer+1 (mod 8) is highest, continuing upward with wrap, down to pointer as lowest.
- Winner: first candidate in priority order. highest_priority_IRR holds its ID; it holds its last value when there are no candidates.
- INT_request = 1 iff a candidate exists whose priority is strictly higher than the highest-priority set ISR bit, using the same rotated order. With ISR=0, any candidate raises it.
- Acknowledge (begin_to_set_ISR=1):
  - ack_id <= current highest_priority_IRR.
  - In edge mode, clear IRR[ack_id].
  - Simultaneous new rising edge on the same bit: set wins, and the bit remains set.
  - Acknowledge while INT_request=0: ack_id <= 3'b111, IRR unchanged (spurious IR7 default).
- Rotation: eoi_pulse & auto_rotate_status -> pointer <= reset_by_EOI, which makes that level lowest priority. eoi_pulse without auto_rotate leaves the pointer unchanged.
- Acknowledge and EOI in the same cycle: both take effect. The new pointer applies from the next cycle.
- OCW1 or LTIM change: takes effect on the next resolution cycle. Switching to level mode discards latched edges and reloads from the synchronised IR.
- Reset mid-acknowledge: all state returns to reset values. A pending acknowledge is lost.

Optional Feature:
- Macro: SPECIAL_MASK_EN.
- With the macro defined:
  - Adds input special_mask_mode (1 bit, set by OCW3 SMM).
  - While it is high, ISR bits that are also masked in OCW1 are ignored in the INT_request comparison, so lower priorities can interrupt.
- Without the macro: the port is absent and all ISR bits always block equal or lower priorities.

Test Plan:
- Reset, then LTIM=0, OCW1=0, pulse IR5 0->1 -> IRR=8'h20 after 3 clk, highest_priority_IRR=5, INT_request=1 one clk later; IR5 dropped before acknowledge -> IRR stays 8'h20.
- IRR=8'hE0 with ISR=0, then begin_to_set_ISR pulse -> ack_id=5, IRR=8'hC0, winner moves to 6. Set ISR=8'h20 -> INT_request=0, because 6 and 7 are lower priority than the in-service level 5.
- OCW1=8'h01 with IR0 and IR3 asserted -> winner=3. Set OCW1=8'h09 -> INT_request=0 next clk, IRR still 8'h09.
- auto_rotate_status=1, eoi_pulse with reset_by_EOI=2 -> pointer=2. With IR1 and IR4 pending -> winner=4.
- LTIM=1, IR6 high for 5 clk then low -> IRR[6] tracks with 3-clk lag. Acknowledge while IR6 is still high -> IRR[6] remains 1. Acknowledge with no request -> ack_id=7.
- Assert reset in the same cycle as begin_to_set_ISR with IRR=8'hFF -> IRR=0, ack_id=0, INT_request=0, pointer=7.
